// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input stage.
//   - PS/2 set-2 scancodes recognised by the keyboard decoder
//   - bit positions of the MiSTer joystick word
//   - indices of the held-key latches and a scancode-to-latch decoder
//   - state type of the coin pulse generator
package arcade_input_pkg;

  // Scancodes (low byte of ps2_key)
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_CTRL  = 8'h14;
  localparam logic [7:0] SC_F1    = 8'h05;
  localparam logic [7:0] SC_F2    = 8'h06;

  // Joystick word bit positions
  localparam int JOY_R      = 0;
  localparam int JOY_L      = 1;
  localparam int JOY_D      = 2;
  localparam int JOY_U      = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;

  // Held-key latch indices
  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_SPACE = 4;
  localparam int KEY_CTRL  = 5;
  localparam int KEY_F1    = 6;
  localparam int KEY_F2    = 7;
  localparam int NUM_KEYS  = 8;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

  // One-hot selection of the latch a scancode controls. Cursor keys share
  // their codes with the numeric keypad, so the extended flag is ignored
  // for them; the remaining keys only match the non-extended code.
  function automatic logic [NUM_KEYS-1:0] key_match(input logic [7:0] code,
                                                    input logic       ext);
    logic [NUM_KEYS-1:0] m;
    m = '0;
    case (code)
      SC_UP:    m[KEY_UP]    = 1'b1;
      SC_DOWN:  m[KEY_DOWN]  = 1'b1;
      SC_LEFT:  m[KEY_LEFT]  = 1'b1;
      SC_RIGHT: m[KEY_RIGHT] = 1'b1;
      SC_SPACE: m[KEY_SPACE] = ~ext;
      SC_CTRL:  m[KEY_CTRL]  = ~ext;
      SC_F1:    m[KEY_F1]    = ~ext;
      SC_F2:    m[KEY_F2]    = ~ext;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/arcade_input_ctrl_coin_pulser.sv
// Coin pulse generator.
// A rising edge of trig (checked against a registered copy) produces a coin
// pulse COIN_PULSE cycles long, starting one cycle after the edge, followed
// by COIN_GAP cycles of lockout. Edges seen while busy are dropped.
// Ports:
//   clk_sys  in   system clock
//   reset    in   synchronous, active-high
//   trig     in   level of the merged start request (s1|s2)
//   coin     out  registered coin pulse
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE = 1200000,
  parameter int COIN_GAP   = 600000,
  parameter int CNT_W      = 21
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic trig,
  output logic coin
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(COIN_PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (COIN_GAP > 0) ? CNT_W'(COIN_GAP - 1) : '0;

  coin_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             trig_prev;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      coin      <= 1'b0;
      trig_prev <= 1'b0;
    end else begin
      // History tracks trig in every state, so a start held through the
      // busy period still needs a fresh edge afterwards.
      trig_prev <= trig;
      case (state)
        IDLE: begin
          if (trig && !trig_prev) begin
            state <= PULSE;
            cnt   <= PULSE_LOAD;
            coin  <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            coin <= 1'b0;
            if (COIN_GAP == 0) begin
              state <= IDLE;
            end else begin
              state <= GAP;
              cnt   <= GAP_LOAD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          coin  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Arcade input stage: PS/2 key decode into held latches, merge with both
// joysticks, orientation remap, and start-driven coin pulse generation.
// Ports:
//   clk_sys     in   system clock
//   reset       in   synchronous, active-high
//   ps2_key     in   [10] toggle, [9] pressed, [8] extended, [7:0] scancode
//   joystick_0  in   [0]R [1]L [2]D [3]U [4]fire [5]start1 [6]start2
//   joystick_1  in   same layout
//   rotate      in   1 = horizontal orientation
//   p1_csjudlr  out  {coin,start1,fire,up,down,left,right}
//   p2_csjudlr  out  {0,start2,fire,up,down,left,right}
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int COIN_PULSE = 1200000,
  parameter int COIN_GAP   = 600000,
  parameter int CNT_W      = 21
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  output logic [6:0]  p1_csjudlr,
  output logic [6:0]  p2_csjudlr
);

  logic                tog_q;
  logic                key_event;
  logic [NUM_KEYS-1:0] key_hit;
  logic                key_reg [NUM_KEYS];

  // Loading the live toggle during reset means a toggle level held through
  // reset is not mistaken for a new event afterwards.
  always_ff @(posedge clk_sys) begin
    tog_q <= ps2_key[10];
  end

  assign key_event = (tog_q != ps2_key[10]);
  assign key_hit   = key_match(ps2_key[7:0], ps2_key[8]);

  // Each key owns its own latch so releasing one fire key leaves the other intact.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      always_ff @(posedge clk_sys) begin
        if (reset) begin
          key_reg[gi] <= 1'b0;
        end else if (key_event && key_hit[gi]) begin
          key_reg[gi] <= ps2_key[9];
        end
      end
    end
  endgenerate

  logic [15:0] joy;
  logic        u, d, l, r, fire, s1, s2;
  logic        up, down, left, right;
  logic        coin;
  logic        unused_joy_bits;

  assign joy  = joystick_0 | joystick_1;
  assign u    = key_reg[KEY_UP]    | joy[JOY_U];
  assign d    = key_reg[KEY_DOWN]  | joy[JOY_D];
  assign l    = key_reg[KEY_LEFT]  | joy[JOY_L];
  assign r    = key_reg[KEY_RIGHT] | joy[JOY_R];
  assign fire = key_reg[KEY_SPACE] | key_reg[KEY_CTRL] | joy[JOY_FIRE];
  assign s1   = key_reg[KEY_F1]    | joy[JOY_START1];
  assign s2   = key_reg[KEY_F2]    | joy[JOY_START2];

  assign unused_joy_bits = ^joy[15:7];

  // Horizontal mode: the cabinet is turned a quarter clockwise, so the
  // player's left becomes the game's up, and so on around the compass.
  always_comb begin
    up    = u;
    down  = d;
    left  = l;
    right = r;
    if (rotate) begin
      up    = l;
      down  = r;
      left  = d;
      right = u;
    end
  end

  coin_pulser #(
    .COIN_PULSE (COIN_PULSE),
    .COIN_GAP   (COIN_GAP),
    .CNT_W      (CNT_W)
  ) u_coin (
    .clk_sys (clk_sys),
    .reset   (reset),
    .trig    (s1 | s2),
    .coin    (coin)
  );

  assign p1_csjudlr = {coin, s1, fire, up, down, left, right};
  assign p2_csjudlr = {1'b0, s2, fire, up, down, left, right};

endmodule

// File: tb/tb_arcade_input_ctrl.sv
module tb_arcade_input_ctrl;

  localparam int P = 4;
  localparam int G = 3;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        rotate;
  logic [6:0]  p1_csjudlr;
  logic [6:0]  p2_csjudlr;

  int checks = 0;
  int errors = 0;

  arcade_input_ctrl #(.COIN_PULSE(P), .COIN_GAP(G), .CNT_W(4)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .joystick_0 (joystick_0),
    .joystick_1 (joystick_1),
    .rotate     (rotate),
    .p1_csjudlr (p1_csjudlr),
    .p2_csjudlr (p2_csjudlr)
  );

  always #5 clk_sys = ~clk_sys;

  // ---------------- behavioural model ----------------
  // held[] order: up, down, left, right, space, ctrl, f1, f2
  bit held [8];
  bit model_valid = 0;
  bit tog_m = 0;
  bit prev_start = 0;
  int cyc = 0;
  int coin_start = -1000;   // first cycle of the current/last coin pulse
  int free_at = 0;          // first cycle a new start edge is accepted

  function automatic int key_slot(input logic [7:0] code, input logic ext);
    int arrows [4] = '{'h75, 'h72, 'h6B, 'h74};
    int others [4] = '{'h29, 'h14, 'h05, 'h06};
    for (int i = 0; i < 4; i++) if (int'(code) == arrows[i]) return i;
    if (!ext) for (int i = 0; i < 4; i++) if (int'(code) == others[i]) return 4 + i;
    return -1;
  endfunction

  always @(negedge clk_sys) begin
    logic [15:0] joy;
    bit u, d, l, r, fire, s1, s2, cn;
    bit dir [4];
    logic [6:0] e1, e2;
    int slot;
    joy  = joystick_0 | joystick_1;
    u    = held[0] | joy[3];
    d    = held[1] | joy[2];
    l    = held[2] | joy[1];
    r    = held[3] | joy[0];
    fire = held[4] | held[5] | joy[4];
    s1   = held[6] | joy[5];
    s2   = held[7] | joy[6];
    if (rotate) dir = '{l, r, d, u}; else dir = '{u, d, l, r};
    cn = (cyc >= coin_start) && (cyc < coin_start + P);
    e1 = {cn, s1, fire, dir[0], dir[1], dir[2], dir[3]};
    e2 = {1'b0, s2, fire, dir[0], dir[1], dir[2], dir[3]};
    if (model_valid) begin
      checks++;
      if (p1_csjudlr !== e1) begin
        errors++;
        $display("FAIL p1_csjudlr cyc=%0d: got %b expected %b", cyc, p1_csjudlr, e1);
      end
      checks++;
      if (p2_csjudlr !== e2) begin
        errors++;
        $display("FAIL p2_csjudlr cyc=%0d: got %b expected %b", cyc, p2_csjudlr, e2);
      end
    end
    // advance model to the state after the coming clock edge
    if (reset) begin
      for (int i = 0; i < 8; i++) held[i] = 0;
      prev_start  = 0;
      coin_start  = -1000;
      free_at     = 0;
      model_valid = 1;
    end else if (model_valid) begin
      if (ps2_key[10] != tog_m) begin
        slot = key_slot(ps2_key[7:0], ps2_key[8]);
        if (slot >= 0) held[slot] = ps2_key[9];
      end
      if ((s1 | s2) && !prev_start && cyc >= free_at) begin
        coin_start = cyc + 1;
        free_at    = cyc + 1 + P + G;
      end
      prev_start = s1 | s2;
    end
    tog_m = ps2_key[10];
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic key_event(input bit pressed, input bit ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    tick();
  endtask

  bit sb   [14] = '{1,1,0,1,0,0,1,0,1,1,1,1,1,1};
  bit cexp [14] = '{0,1,1,1,1,0,0,0,0,1,1,1,1,0};

  initial begin
    reset = 1; ps2_key = '0; joystick_0 = '0; joystick_1 = '0; rotate = 0;
    repeat (3) tick();
    reset = 0;
    tick();
    chk("reset_p1", p1_csjudlr, 7'd0);
    chk("reset_p2", p2_csjudlr, 7'd0);

    // 1. key hold/release
    key_event(1, 1, 8'h75); chk("up_ext_press", {6'd0, p1_csjudlr[3]}, 7'd1);
    key_event(0, 1, 8'h75); chk("up_release",   {6'd0, p1_csjudlr[3]}, 7'd0);
    key_event(1, 0, 8'h75); chk("up_noext",     {6'd0, p1_csjudlr[3]}, 7'd1);
    key_event(0, 0, 8'h75);
    $display("test1 keys done cyc=%0d", cyc);

    // 2. fire sources
    key_event(1, 0, 8'h29); chk("space_fire", {6'd0, p1_csjudlr[4]}, 7'd1);
    key_event(1, 0, 8'h14);
    key_event(0, 0, 8'h29); chk("ctrl_holds_fire", {6'd0, p1_csjudlr[4]}, 7'd1);
    key_event(0, 0, 8'h14); chk("fire_released",   {6'd0, p1_csjudlr[4]}, 7'd0);
    key_event(1, 1, 8'h29); chk("ext_space_ignored", {6'd0, p2_csjudlr[4]}, 7'd0);
    $display("test2 fire done cyc=%0d", cyc);

    // 3. rotate
    rotate = 1; joystick_0 = 16'h0008; tick();
    chk("rot_up_to_right", {3'd0, p1_csjudlr[3:0]}, 7'b0000001);
    joystick_0 = 16'h0000; joystick_1 = 16'h0002; tick();
    chk("rot_left_to_up", {3'd0, p1_csjudlr[3:0]}, 7'b0001000);
    joystick_1 = '0; rotate = 0;
    repeat (10) tick();
    $display("test3 rotate done cyc=%0d", cyc);

    // 4. coin timing with start held
    joystick_0 = 16'h0020; #1;
    chk("coin_edge_cycle", {6'd0, p1_csjudlr[6]}, 7'd0);
    tick();
    for (int i = 0; i < P; i++) begin
      chk("coin_on", {5'd0, p1_csjudlr[6:5]}, 7'b0000011);
      tick();
    end
    chk("coin_off", {5'd0, p1_csjudlr[6:5]}, 7'b0000001);
    repeat (6) begin
      tick();
      chk("coin_no_retrigger", {5'd0, p1_csjudlr[6:5]}, 7'b0000001);
    end
    joystick_0 = '0;
    repeat (10) tick();
    $display("test4 coin done cyc=%0d", cyc);

    // 5. lockout
    for (int k = 0; k < 14; k++) begin
      joystick_0 = sb[k] ? 16'h0020 : 16'h0000;
      #1;
      chk($sformatf("lockout_k%0d", k), {6'd0, p1_csjudlr[6]}, {6'd0, cexp[k]});
      tick();
    end
    joystick_0 = '0;
    repeat (10) tick();
    $display("test5 lockout done cyc=%0d", cyc);

    // 6. reset mid-pulse, toggle held high through reset
    key_event(1, 0, 8'h75);
    if (ps2_key[10] == 1'b0) key_event(1, 0, 8'h75);
    joystick_0 = 16'h0020; tick(); tick();
    chk("pre_reset_coin", {6'd0, p1_csjudlr[6]}, 7'd1);
    reset = 1; joystick_0 = '0; tick();
    chk("reset_mid_p1", p1_csjudlr, 7'd0);
    chk("reset_mid_p2", p2_csjudlr, 7'd0);
    reset = 0; tick();
    chk("no_phantom_event", p1_csjudlr, 7'd0);
    tick();
    chk("no_phantom_event2", p1_csjudlr, 7'd0);
    $display("test6 reset done cyc=%0d", cyc);

    // random phase against the model
    for (int n = 0; n < 3000; n++) begin
      int sel;
      logic [7:0] codes [8] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h06};
      reset = ($urandom_range(0, 99) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 3) begin
        ps2_key = {~ps2_key[10], 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 4) == 0) ? 8'($urandom) : codes[$urandom_range(0, 7)]};
      end else if (sel == 3) begin
        ps2_key = {ps2_key[10], 10'($urandom)};
      end
      if ($urandom_range(0, 9) == 0)
        joystick_0 = 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 9) == 0)
        joystick_1 = 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 19) == 0) rotate = ~rotate;
      tick();
    end
    reset = 0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
